// File: rtl/risc_pkg.sv
// Shared widths, instruction field positions and fetch FSM state encoding
// for the instruction fetch slice.
package risc_pkg;

    localparam int OPCODE_W = 3;
    localparam int REG_W    = 3;
    localparam int IMM_W    = 7;
    localparam int INSTR_W  = 16;
    localparam int ADDR_W   = 8;

    // Least-significant bit of each field inside the instruction register
    localparam int OPC_LSB = 13;
    localparam int RS_LSB  = 10;
    localparam int RT_LSB  = 7;
    localparam int RD_LSB  = 4;
    localparam int IMM_LSB = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FLUSH = 2'd2,
        ISSUE = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction-memory read port: request/address out, ack/data back.
interface instruction_fetch_if #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16
);
    logic               IMemReq;
    logic [ADDR_W-1:0]  IMemAddr;
    logic               IMemAck;
    logic [INSTR_W-1:0] IMemData;

    modport master (
        output IMemReq,
        output IMemAddr,
        input  IMemAck,
        input  IMemData
    );

    modport slave (
        input  IMemReq,
        input  IMemAddr,
        output IMemAck,
        output IMemData
    );
endinterface

// File: rtl/instruction_fetch_pc_counter.sv
// Program counter: redirect load has priority over sequential increment;
// the increment wraps silently at 2^ADDR_W.
module pc_counter #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic              i_inc,
    input  logic [ADDR_W-1:0] i_target,
    output logic [ADDR_W-1:0] o_pc,
    output logic [ADDR_W-1:0] o_pc_plus1
);

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_plus1;

    assign w_pc_plus1 = r_pc + ADDR_W'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc <= '0;
        end else if (i_load) begin
            r_pc <= i_target;
        end else if (i_inc) begin
            r_pc <= w_pc_plus1;
        end
    end

    assign o_pc       = r_pc;
    assign o_pc_plus1 = w_pc_plus1;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch FSM and instruction register; decoded fields come straight from IR.
//   state | meaning
//   IDLE  | one cycle after reset, launches the first request at PC
//   FETCH | request at IMemAddr held until ack; ack loads IR
//   FLUSH | redirected while a request was open; drain it, discard data
//   ISSUE | IR is live on the outputs; advance, redirect or hold on stall
module instruction_fetch
    import risc_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    instruction_fetch_if.master       imem,
    input  logic                      Stall,
    input  logic                      Branch,
    input  logic [ADDR_W-1:0]         BranchTarget,
    output logic                      InstrValid,
    output logic [OPCODE_W-1:0]       OpCode,
    output logic [REG_W-1:0]          Rs,
    output logic [REG_W-1:0]          Rt,
    output logic [REG_W-1:0]          Rd,
    output logic [IMM_W-1:0]          Imm,
    output logic [INSTR_W-1:0]        ImmExt,
    output logic [ADDR_W-1:0]         PC,
    output logic [ADDR_W-1:0]         PCPlus1
);

    fetch_state_t       r_state;
    logic [INSTR_W-1:0] r_ir;
    logic               r_req;
    logic [ADDR_W-1:0]  r_addr;
    logic               r_valid;

    logic               w_pc_load;
    logic               w_pc_inc;
    logic [ADDR_W-1:0]  w_pc;
    logic [ADDR_W-1:0]  w_pc_plus1;

    // Redirects are taken in every state but IDLE; increment only on a free issue
    assign w_pc_load = Branch && (r_state != IDLE);
    assign w_pc_inc  = (r_state == ISSUE) && !Branch && !Stall;

    pc_counter #(
        .ADDR_W (ADDR_W)
    ) u_pc_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_pc_load),
        .i_inc      (w_pc_inc),
        .i_target   (BranchTarget),
        .o_pc       (w_pc),
        .o_pc_plus1 (w_pc_plus1)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ir    <= '0;
            r_req   <= 1'b0;
            r_addr  <= '0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_state <= FETCH;
                    r_req   <= 1'b1;
                    r_addr  <= w_pc;
                end
                FETCH: begin
                    if (Branch) begin
                        // Open request must finish at its original address
                        if (imem.IMemAck) begin
                            r_state <= FETCH;
                            r_addr  <= BranchTarget;
                        end else begin
                            r_state <= FLUSH;
                        end
                    end else if (imem.IMemAck) begin
                        r_ir    <= imem.IMemData;
                        r_req   <= 1'b0;
                        r_valid <= 1'b1;
                        r_state <= ISSUE;
                    end
                end
                FLUSH: begin
                    if (imem.IMemAck) begin
                        r_state <= FETCH;
                        r_addr  <= Branch ? BranchTarget : w_pc;
                    end
                end
                ISSUE: begin
                    if (Branch) begin
                        r_valid <= 1'b0;
                        r_req   <= 1'b1;
                        r_addr  <= BranchTarget;
                        r_state <= FETCH;
                    end else if (!Stall) begin
                        r_valid <= 1'b0;
                        r_req   <= 1'b1;
                        r_addr  <= w_pc_plus1;
                        r_state <= FETCH;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_req   <= 1'b0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign imem.IMemReq  = r_req;
    assign imem.IMemAddr = r_addr;

    assign InstrValid = r_valid;
    assign OpCode     = r_ir[OPC_LSB +: OPCODE_W];
    assign Rs         = r_ir[RS_LSB +: REG_W];
    assign Rt         = r_ir[RT_LSB +: REG_W];
    assign Rd         = r_ir[RD_LSB +: REG_W];
    assign Imm        = r_ir[IMM_LSB +: IMM_W];
    assign ImmExt     = {{(INSTR_W-IMM_W){r_ir[IMM_LSB+IMM_W-1]}}, r_ir[IMM_LSB +: IMM_W]};
    assign PC         = w_pc;
    assign PCPlus1    = w_pc_plus1;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: decode table over sequential fetches,
// then stall, redirect, wrap and mid-fetch reset sequences.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        Stall = 1'b0;
    logic        Branch = 1'b0;
    logic [7:0]  BranchTarget = '0;
    logic        InstrValid;
    logic [2:0]  OpCode, Rs, Rt, Rd;
    logic [6:0]  Imm;
    logic [15:0] ImmExt;
    logic [7:0]  PC, PCPlus1;

    int checks = 0;
    int failures = 0;

    instruction_fetch_if #(.ADDR_W(8), .INSTR_W(16)) ifc ();

    instruction_fetch #(.ADDR_W(8), .INSTR_W(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem         (ifc.master),
        .Stall        (Stall),
        .Branch       (Branch),
        .BranchTarget (BranchTarget),
        .InstrValid   (InstrValid),
        .OpCode       (OpCode),
        .Rs           (Rs),
        .Rt           (Rt),
        .Rd           (Rd),
        .Imm          (Imm),
        .ImmExt       (ImmExt),
        .PC           (PC),
        .PCPlus1      (PCPlus1)
    );

    always #5 clk = ~clk;

    // Memory model: ack after mem_lat waiting negedges of a held request
    logic [15:0] mem [256];
    int          mem_lat = 0;
    int          mem_cnt = 0;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_data = '0;

    assign ifc.IMemAck  = mem_ack;
    assign ifc.IMemData = mem_data;

    always @(negedge clk) begin
        if (ifc.IMemReq && !mem_ack && mem_cnt >= mem_lat) begin
            mem_ack  <= 1'b1;
            mem_data <= mem[ifc.IMemAddr];
            mem_cnt  <= 0;
        end else begin
            mem_ack <= 1'b0;
            mem_cnt <= (ifc.IMemReq && !mem_ack) ? mem_cnt + 1 : 0;
        end
    end

    typedef struct {
        logic [15:0] instr;
        logic [2:0]  op;
        logic [2:0]  rs;
        logic [2:0]  rt;
        logic [2:0]  rd;
        logic [6:0]  imm;
        logic [15:0] immext;
    } vec_t;

    vec_t vecs [6];

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wait_valid(input int limit, output int n);
        n = 0;
        while (!InstrValid && n < limit) begin
            tick();
            n++;
        end
        chk("valid_within_budget", {31'd0, InstrValid}, 32'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req"},    {31'd0, ifc.IMemReq}, 0);
        chk({tag, "_addr"},   {24'd0, ifc.IMemAddr}, 0);
        chk({tag, "_valid"},  {31'd0, InstrValid}, 0);
        chk({tag, "_fields"}, {OpCode, Rs, Rt, Rd, Imm}, 0);
        chk({tag, "_immext"}, {16'd0, ImmExt}, 0);
        chk({tag, "_pc"},     {24'd0, PC}, 0);
    endtask

    initial begin
        int n;
        int held;

        for (int a = 0; a < 256; a++) mem[a] = 16'h0000;
        vecs[0] = '{16'h8000, 3'd4, 3'd0, 3'd0, 3'd0, 7'h00, 16'h0000};
        vecs[1] = '{16'hE000, 3'd7, 3'd0, 3'd0, 3'd0, 7'h00, 16'h0000};
        vecs[2] = '{16'h9234, 3'd4, 3'd4, 3'd4, 3'd3, 7'h34, 16'h0034};
        vecs[3] = '{16'h0040, 3'd0, 3'd0, 3'd0, 3'd4, 7'h40, 16'hFFC0};
        vecs[4] = '{16'h5A7F, 3'd2, 3'd6, 3'd4, 3'd7, 7'h7F, 16'hFFFF};
        vecs[5] = '{16'h2C3F, 3'd1, 3'd3, 3'd0, 3'd3, 7'h3F, 16'h003F};
        for (int i = 0; i < 6; i++) mem[i] = vecs[i].instr;
        mem[8'h10] = 16'hA5A5;
        mem[8'h11] = 16'hE000;
        mem[8'h40] = 16'hC000;
        mem[8'hFF] = 16'h0040;

        // Reset; Branch during IDLE must be ignored
        rst_n = 1'b0;
        tick();
        chk_all_zero("reset");
        tick();
        rst_n = 1'b1;
        Branch = 1'b1;
        BranchTarget = 8'h55;
        tick();
        Branch = 1'b0;
        chk("idle_to_fetch_req", {31'd0, ifc.IMemReq}, 1);
        chk("idle_ignores_branch_addr", {24'd0, ifc.IMemAddr}, 0);
        chk("fetch_not_valid", {31'd0, InstrValid}, 0);

        // Zero-wait sequential fetch through the decode table
        for (int i = 0; i < 6; i++) begin
            wait_valid(10, n);
            if (i > 0) chk($sformatf("v%0d_spacing", i), n, 1);
            chk($sformatf("v%0d_op", i),     {29'd0, OpCode}, {29'd0, vecs[i].op});
            chk($sformatf("v%0d_regs", i),   {23'd0, Rs, Rt, Rd}, {23'd0, vecs[i].rs, vecs[i].rt, vecs[i].rd});
            chk($sformatf("v%0d_imm", i),    {25'd0, Imm}, {25'd0, vecs[i].imm});
            chk($sformatf("v%0d_immext", i), {16'd0, ImmExt}, {16'd0, vecs[i].immext});
            chk($sformatf("v%0d_pc", i),     {24'd0, PC}, i);
            chk($sformatf("v%0d_pcp1", i),   {24'd0, PCPlus1}, i + 1);
            chk($sformatf("v%0d_req_low", i), {31'd0, ifc.IMemReq}, 0);
            if (i < 5) begin
                tick();
                chk($sformatf("v%0d_valid_drop", i), {31'd0, InstrValid}, 0);
            end
        end

        // Redirect to 0x9234 at address 2, then stall five cycles
        Branch = 1'b1;
        BranchTarget = 8'h02;
        tick();
        Branch = 1'b0;
        chk("br2_valid", {31'd0, InstrValid}, 0);
        chk("br2_addr", {24'd0, ifc.IMemAddr}, 8'h02);
        Stall = 1'b1;
        wait_valid(10, n);
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("stall%0d_op", c), {29'd0, OpCode}, 3'd4);
            chk($sformatf("stall%0d_regs", c), {23'd0, Rs, Rt, Rd}, {23'd0, 3'd4, 3'd4, 3'd3});
            chk($sformatf("stall%0d_pc", c), {24'd0, PC}, 8'h02);
            chk($sformatf("stall%0d_req", c), {31'd0, ifc.IMemReq}, 0);
            chk($sformatf("stall%0d_valid", c), {31'd0, InstrValid}, 1);
            tick();
        end

        // Branch wins over Stall
        Branch = 1'b1;
        BranchTarget = 8'h40;
        tick();
        Branch = 1'b0;
        Stall = 1'b0;
        chk("brstall_valid", {31'd0, InstrValid}, 0);
        chk("brstall_addr", {24'd0, ifc.IMemAddr}, 8'h40);
        chk("brstall_req", {31'd0, ifc.IMemReq}, 1);
        wait_valid(10, n);
        chk("t40_pc", {24'd0, PC}, 8'h40);
        chk("t40_op", {29'd0, OpCode}, 3'd6);

        // Wrap at 0xFF and negative immediate
        Branch = 1'b1;
        BranchTarget = 8'hFF;
        tick();
        Branch = 1'b0;
        wait_valid(10, n);
        chk("wrap_pc", {24'd0, PC}, 8'hFF);
        chk("wrap_pcp1", {24'd0, PCPlus1}, 8'h00);
        chk("wrap_imm", {25'd0, Imm}, 7'h40);
        chk("wrap_immext", {16'd0, ImmExt}, 16'hFFC0);
        tick();
        chk("wrap_addr", {24'd0, ifc.IMemAddr}, 8'h00);
        chk("wrap_req", {31'd0, ifc.IMemReq}, 1);
        wait_valid(10, n);
        chk("wrap_next_pc", {24'd0, PC}, 8'h00);
        chk("wrap_next_op", {29'd0, OpCode}, 3'd4);

        // Branch coincident with ack in FETCH: returned word dropped
        tick();
        chk("coinc_pre_addr", {24'd0, ifc.IMemAddr}, 8'h01);
        Branch = 1'b1;
        BranchTarget = 8'h10;
        tick();
        Branch = 1'b0;
        chk("coinc_valid", {31'd0, InstrValid}, 0);
        chk("coinc_addr", {24'd0, ifc.IMemAddr}, 8'h10);
        chk("coinc_req", {31'd0, ifc.IMemReq}, 1);
        wait_valid(10, n);
        chk("coinc_pc", {24'd0, PC}, 8'h10);
        chk("coinc_op", {29'd0, OpCode}, 3'd5);

        // Branch in FETCH with ack delayed three cycles: FLUSH holds old address
        mem_lat = 3;
        tick();
        chk("late_pre_addr", {24'd0, ifc.IMemAddr}, 8'h11);
        Branch = 1'b1;
        BranchTarget = 8'h10;
        tick();
        Branch = 1'b0;
        held = 0;
        while (ifc.IMemAddr == 8'h11 && held < 10) begin
            chk($sformatf("flush%0d_req", held), {31'd0, ifc.IMemReq}, 1);
            chk($sformatf("flush%0d_valid", held), {31'd0, InstrValid}, 0);
            held++;
            tick();
        end
        chk("flush_hold_cycles", held, 3);
        chk("flush_new_addr", {24'd0, ifc.IMemAddr}, 8'h10);
        chk("flush_new_req", {31'd0, ifc.IMemReq}, 1);
        wait_valid(20, n);
        chk("flush_pc", {24'd0, PC}, 8'h10);
        chk("flush_op", {29'd0, OpCode}, 3'd5);

        // One-cycle reset in the middle of a fetch
        tick();
        chk("rst_pre_req", {31'd0, ifc.IMemReq}, 1);
        rst_n = 1'b0;
        tick();
        chk_all_zero("midrst");
        rst_n = 1'b1;
        tick();
        chk("midrst_req", {31'd0, ifc.IMemReq}, 1);
        chk("midrst_addr", {24'd0, ifc.IMemAddr}, 0);
        wait_valid(20, n);
        chk("midrst_pc", {24'd0, PC}, 0);
        chk("midrst_op", {29'd0, OpCode}, 3'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter ADDR_W, default 8, SHALL set the word-address (PC) width.
REQ-002 Parameter INSTR_W, default 16, SHALL set the instruction width.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  SHALL be the reset, synchronous and active-low.
REQ-005 IMemReq  out  1  instruction-memory read request.
REQ-006 IMemAddr  out  ADDR_W  read word address.
REQ-007 IMemAck  in  1  read data valid; may assert in the same cycle as IMemReq.
REQ-008 IMemData  in  INSTR_W  instruction word, sampled only when IMemAck=1.
REQ-009 Stall  in  1  downstream hold request.
REQ-010 Branch  in  1  redirect request from execute.
REQ-011 BranchTarget  in  ADDR_W  redirect address.
REQ-012 InstrValid  out  1  fields below hold a live instruction.
REQ-013 OpCode  out  3  IR[15:13], consumed by the control unit.
REQ-014 Rs, Rt, Rd  out  3 each  IR[12:10], IR[9:7], IR[6:4].
REQ-015 Imm  out  7  IR[6:0]; ImmExt  out  INSTR_W  Imm sign-extended.
REQ-016 PC  out  ADDR_W  address of the issued instruction; PCPlus1  out  ADDR_W  PC+1 mod 2^ADDR_W.

Function
REQ-017 FSM states IDLE, FETCH, FLUSH, ISSUE; IDLE SHALL be occupied exactly one cycle after reset release, then FETCH.
REQ-018 FETCH: IMemReq=1, IMemAddr=PC, both stable until IMemAck; on IMemAck IR<=IMemData, next state ISSUE.
REQ-019 ISSUE: InstrValid=1, IMemReq=0, fields driven from IR only (never combinationally from IMemData).
REQ-020 ISSUE with Branch=1: PC<=BranchTarget, InstrValid 0 next cycle, next state FETCH; Branch SHALL win over Stall.
REQ-021 ISSUE with Stall=1, Branch=0: IR, PC, outputs held unchanged, stay ISSUE.
REQ-022 ISSUE with Stall=0, Branch=0: PC<=PC+1, next state FETCH.
REQ-023 PC increment SHALL wrap 2^ADDR_W-1 -> 0 without flag.
REQ-024 Branch in FETCH without IMemAck: PC<=BranchTarget, next state FLUSH; IMemAddr SHALL keep the old address while IMemReq held.
REQ-025 Branch in FETCH coincident with IMemAck: returned word discarded, PC<=BranchTarget, next state FETCH.
REQ-026 FLUSH: IMemReq=1 at old address until IMemAck; data discarded; next state FETCH at redirected PC; Branch in FLUSH updates target again.
REQ-027 Branch, Stall SHALL be ignored in IDLE; Stall ignored in FETCH/FLUSH.
REQ-028 Latency: IMemAck at cycle n -> InstrValid at n+1; zero-wait memory gives one instruction per 2 cycles.
REQ-029 ImmExt SHALL replicate Imm[6] into bits INSTR_W-1:7.

Reset
REQ-030 While rst_n=0 at a clock edge: state IDLE, PC=0, IR=0, IMemReq=0, InstrValid=0, OpCode=0, all fields 0, IMemAddr=0.
REQ-031 Reset mid-fetch SHALL abandon the request; a late IMemAck after reset SHALL be ignored outside FETCH/FLUSH.

Structure
REQ-032 Shared package risc_pkg SHALL hold OPCODE_W=3, REG_W=3, INSTR_W, ADDR_W, field bit positions, and the FSM state enumeration.
REQ-033 PC register, increment, wrap and redirect mux SHALL be one sub-module pc_counter; FSM and IR stay in instruction_fetch.

Verification
REQ-034 Reset, zero-wait memory returning 0x8000,0xE000 at 0,1 -> OpCode 3'b100 then 3'b111, PC 0 then 1, InstrValid every second cycle.
REQ-035 Stall=1 for 5 cycles in ISSUE with IR=0x9234 -> OpCode, Rs=4, Rt=4, Rd=3, PC frozen, IMemReq=0 throughout.
REQ-036 Branch=1, BranchTarget=0x40 in ISSUE with Stall=1 -> next IMemAddr=0x40, InstrValid=0 next cycle.
REQ-037 Branch to 0x10 during FETCH with IMemAck delayed 3 cycles -> IMemAddr old value until ack, data dropped, then request at 0x10.
REQ-038 PC=0xFF issue, Stall=0 -> next IMemAddr=0x00; Imm=7'b1000000 -> ImmExt=0xFFC0.
REQ-039 rst_n=0 one cycle during FETCH -> all outputs zero next cycle, IDLE, refetch from address 0.
